// File: rtl/adder_measure_sequencer_pkg.sv
// Shared definitions for the adder delay-measurement sequencer.
//   state_t      : sequencer states
//   DRAIN_CYCLES : clocks spent counting late edges after the ring is opened
//   SYNC_STAGES  : synchroniser depth ahead of the edge-detect flop
package adder_measure_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DRAIN_CYCLES = 3;
  localparam int SYNC_STAGES  = 2;

endpackage

// File: rtl/adder_measure_sequencer_ring_edge_counter.sv
// Ring edge counter: synchronises the asynchronous ring tap, detects rising
// edges and counts them with saturation.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_tap          : asynchronous ring tap
//   i_clear        : synchronous clear of count and overflow (wins over enable)
//   i_enable       : count detected edges while high
//   o_count        : saturating edge count
//   o_ovf          : sticky, set when an edge arrives with the count at max
// Only rings slower than i_clk/2 are counted correctly; faster rings alias
// and nothing here detects that.
module adder_measure_sequencer_ring_edge_counter
  import adder_measure_sequencer_pkg::*;
#(
  parameter int COUNT_W = 24
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tap,
  input  logic               i_clear,
  input  logic               i_enable,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_ovf
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_tap_d;
  logic [COUNT_W-1:0]     r_count;
  logic                   r_ovf;
  logic                   w_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_tap_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_tap};
      r_tap_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_tap_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_enable && w_edge) begin
      if (&r_count) r_ovf <= 1'b1;
      else          r_count <= r_count + COUNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/adder_measure_sequencer.sv
// Adder delay-measurement sequencer: latches an adder configuration, lets it
// settle with the ring open, closes the ring for a programmed window and
// reports the number of ring edges seen.
//   wb_clk_i, wb_rst_n      : system clock, async active-low reset
//   start, abort            : command bits (start sampled only in IDLE)
//   cfg_*                   : configuration captured on an accepted start
//   ring_tap                : asynchronous ring output
//   adder_*                 : captured configuration driven to the adder
//   ring_en                 : closes the ring while high
//   busy, done              : status; done pulses once per completed run
//   result, overflow        : last completed count and its saturation flag
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | config applied, ring open, SETTLE_CYCLES clocks
// RUN    | ring closed, counting edges for window clocks
// DRAIN  | ring open, still counting edges in flight in the synchroniser
// DONE   | publish result/overflow, pulse done
module adder_measure_sequencer
  import adder_measure_sequencer_pkg::*;
#(
  parameter int COUNT_W       = 24,
  parameter int WINDOW_W      = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          cfg_input_a,
  input  logic [7:0]          cfg_xor_enable,
  input  logic [7:0]          cfg_add_enable,
  input  logic [WINDOW_W-1:0] cfg_window,
  input  logic                ring_tap,
  output logic [7:0]          adder_input_a,
  output logic [7:0]          adder_xor_enable,
  output logic [7:0]          adder_add_enable,
  output logic                ring_en,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  result,
  output logic                overflow
);

  state_t              r_state;
  logic [WINDOW_W-1:0] r_timer;
  logic [WINDOW_W-1:0] r_window;
  logic [7:0]          r_input_a;
  logic [7:0]          r_xor_enable;
  logic [7:0]          r_add_enable;
  logic                r_ring_en;
  logic                r_busy;
  logic                r_done;
  logic [COUNT_W-1:0]  r_result;
  logic                r_overflow;

  logic                w_timer_tc;
  logic                w_cnt_clr;
  logic                w_cnt_en;
  logic [COUNT_W-1:0]  w_count;
  logic                w_ovf;

  // Timer is a down-counter loaded with (length - 1); a phase ends on the
  // clock where it reads zero, so a full 2^WINDOW_W-1 window never wraps.
  assign w_timer_tc = (r_timer == '0);
  assign w_cnt_clr  = (r_state == ST_IDLE) && start;
  assign w_cnt_en   = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  adder_measure_sequencer_ring_edge_counter #(
    .COUNT_W (COUNT_W)
  ) u_ring_edge_counter (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_n),
    .i_tap    (ring_tap),
    .i_clear  (w_cnt_clr),
    .i_enable (w_cnt_en),
    .o_count  (w_count),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_window     <= '0;
      r_input_a    <= '0;
      r_xor_enable <= '0;
      r_add_enable <= '0;
      r_ring_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // adder_* are left as captured on abort so the adder stays static.
      if (abort && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_ring_en <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_input_a    <= cfg_input_a;
              r_xor_enable <= cfg_xor_enable;
              r_add_enable <= cfg_add_enable;
              r_window     <= cfg_window;
              r_timer      <= WINDOW_W'(SETTLE_CYCLES - 1);
              r_busy       <= 1'b1;
              r_state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (w_timer_tc) begin
              if (r_window != '0) begin
                r_timer   <= r_window - WINDOW_W'(1);
                r_ring_en <= 1'b1;
                r_state   <= ST_RUN;
              end else begin
                r_timer <= WINDOW_W'(DRAIN_CYCLES - 1);
                r_state <= ST_DRAIN;
              end
            end else begin
              r_timer <= r_timer - WINDOW_W'(1);
            end
          end
          ST_RUN: begin
            if (w_timer_tc) begin
              r_timer   <= WINDOW_W'(DRAIN_CYCLES - 1);
              r_ring_en <= 1'b0;
              r_state   <= ST_DRAIN;
            end else begin
              r_timer <= r_timer - WINDOW_W'(1);
            end
          end
          ST_DRAIN: begin
            if (w_timer_tc) r_state <= ST_DONE;
            else            r_timer <= r_timer - WINDOW_W'(1);
          end
          ST_DONE: begin
            r_result   <= w_count;
            r_overflow <= w_ovf;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
          default: begin
            r_ring_en <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign adder_input_a    = r_input_a;
  assign adder_xor_enable = r_xor_enable;
  assign adder_add_enable = r_add_enable;
  assign ring_en          = r_ring_en;
  assign busy             = r_busy;
  assign done             = r_done;
  assign result           = r_result;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Bench for adder_measure_sequencer: a default instance plus one with a
// 4-bit counter and 8-bit window for saturation and window-length corners.
module tb_adder_measure_sequencer;

  typedef struct {
    logic [15:0] win;
    int          per;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  d;
    logic [23:0] res;
    logic        ovf;
    int          lat;
    int          ren;
    bit          c4;
    logic [3:0]  res4;
    logic        ovf4;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ring_tap = 1'b0;
  logic [7:0]  cfg_a = '0, cfg_x = '0, cfg_d = '0;
  logic [15:0] cfg_window = '0;

  logic [7:0]  ad_a, ad_x, ad_d;
  logic        ren, busy, done, ovf;
  logic [23:0] result;
  logic [7:0]  ad_a4, ad_x4, ad_d4;
  logic        ren4, busy4, done4, ovf4;
  logic [3:0]  result4;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ren_cnt = 0;
  int ren4_cnt = 0;
  int tap_p = 0;
  vec_t vecs[10];

  adder_measure_sequencer u_dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
    .cfg_input_a(cfg_a), .cfg_xor_enable(cfg_x), .cfg_add_enable(cfg_d),
    .cfg_window(cfg_window), .ring_tap(ring_tap),
    .adder_input_a(ad_a), .adder_xor_enable(ad_x), .adder_add_enable(ad_d),
    .ring_en(ren), .busy(busy), .done(done), .result(result), .overflow(ovf)
  );

  adder_measure_sequencer #(.COUNT_W(4), .WINDOW_W(8), .SETTLE_CYCLES(4)) u_dut4 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
    .cfg_input_a(cfg_a), .cfg_xor_enable(cfg_x), .cfg_add_enable(cfg_d),
    .cfg_window(cfg_window[7:0]), .ring_tap(ring_tap),
    .adder_input_a(ad_a4), .adder_xor_enable(ad_x4), .adder_add_enable(ad_d4),
    .ring_en(ren4), .busy(busy4), .done(done4), .result(result4), .overflow(ovf4)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(negedge clk);
    if (ren)  ren_cnt++;
    if (ren4) ren4_cnt++;
  end

  // Ring model: while ring_en is high, a square wave of period tap_p whose
  // first high phase starts right after ring_en rises; low otherwise.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #2;
      if (ren && tap_p > 0) begin
        ring_tap = (ph < tap_p / 2);
        ph = (ph + 1 >= tap_p) ? 0 : ph + 1;
      end else begin
        ring_tap = 1'b0;
        ph = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic wait_done(input int t0, input int budget, output int lat, output int lat4);
    lat = -1; lat4 = -1;
    for (int n = 0; n < budget && lat < 0; n++) begin
      @(posedge clk); #1;
      if (done4 && lat4 < 0) lat4 = cyc - t0;
      if (done) lat = cyc - t0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t0, lat, lat4;
    @(posedge clk); #1;
    cfg_a = v.a; cfg_x = v.x; cfg_d = v.d; cfg_window = v.win;
    tap_p = v.per; ren_cnt = 0; ren4_cnt = 0; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
    check("busy_after_start", busy, 1);
    check("adder_cfg", {ad_a, ad_x, ad_d}, {v.a, v.x, v.d});
    wait_done(t0, v.lat + 20, lat, lat4);
    check("done_latency", lat, v.lat);
    check("result", result, v.res);
    check("overflow", ovf, v.ovf);
    check("busy_at_done", busy, 0);
    check("ring_en_cycles", ren_cnt, v.ren);
    if (v.c4) begin
      check("done_latency_w4", lat4, v.lat);
      check("result_w4", result4, v.res4);
      check("overflow_w4", ovf4, v.ovf4);
      check("ring_en_cycles_w4", ren4_cnt, v.ren);
    end
    @(posedge clk); #1;
    check("done_single_cycle", done, 0);
    check("result_held", result, v.res);
  endtask

  initial begin
    int t0, lat, lat4, seen;

    //          win   per  a      x      d      res  ovf lat   ren  c4 res4 ovf4
    vecs[0] = '{1000, 10, 8'hA1, 8'h0F, 8'hF0, 100, 0, 1008, 1000, 0, 0,  0};
    vecs[1] = '{0,    10, 8'h01, 8'h02, 8'h03, 0,   0, 8,    0,    1, 0,  0};
    vecs[2] = '{200,  4,  8'h10, 8'h20, 8'h30, 50,  0, 208,  200,  1, 15, 1};
    vecs[3] = '{20,   4,  8'h11, 8'h21, 8'h31, 5,   0, 28,   20,   1, 5,  0};
    vecs[4] = '{60,   4,  8'h12, 8'h22, 8'h32, 15,  0, 68,   60,   1, 15, 0};
    vecs[5] = '{64,   4,  8'h13, 8'h23, 8'h33, 16,  0, 72,   64,   1, 15, 1};
    vecs[6] = '{15,   6,  8'hFF, 8'h00, 8'hFF, 3,   0, 23,   15,   1, 3,  0};
    vecs[7] = '{255,  4,  8'h55, 8'hAA, 8'h55, 64,  0, 263,  255,  1, 15, 1};
    vecs[8] = '{1,    4,  8'h80, 8'h40, 8'h20, 1,   0, 9,    1,    1, 1,  0};
    vecs[9] = '{420,  10, 8'h42, 8'h24, 8'h81, 42,  0, 428,  420,  0, 0,  0};

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done_ring_en", {done, ren}, 0);
    check("reset_result_ovf", {result, ovf}, 0);
    check("reset_adder", {ad_a, ad_x, ad_d}, 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // abort at RUN cycle 10 with a prior result of 42
    @(posedge clk); #1;
    cfg_window = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) begin @(posedge clk); #1; end
    check("abort_pre_ring_en", ren, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ring_en", ren, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 42);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done) seen = 1; end
    check("abort_no_done", seen, 0);
    check("abort_result_kept", {result, ovf}, {24'd42, 1'b0});
    check("abort_adder_static", {ad_a, ad_x, ad_d}, 24'h422481);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_no_effect", {busy, result}, {1'b0, 24'd42});

    // async reset at RUN cycle 50
    @(posedge clk); #1;
    cfg_a = 8'h9C; cfg_x = 8'h3E; cfg_d = 8'h77; cfg_window = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (53) @(posedge clk);
    #1;
    check("rst_pre_ring_en", ren, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ring_en_busy_done", {ren, busy, done}, 0);
    check("rst_async_result_ovf", {result, ovf}, 0);
    check("rst_async_adder", {ad_a, ad_x, ad_d}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_release_idle", {busy, ren, done}, 0);

    // start pulsed while busy with different cfg
    @(posedge clk); #1;
    cfg_a = 8'h11; cfg_x = 8'h22; cfg_d = 8'h33; cfg_window = 16'd50; tap_p = 10; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    cfg_a = 8'hEE; cfg_x = 8'hEE; cfg_d = 8'hEE; cfg_window = 16'd5; start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    check("busy_start_adder_held", {ad_a, ad_x, ad_d}, 24'h112233);
    wait_done(t0, 100, lat, lat4);
    check("busy_start_latency", lat, 58);
    check("busy_start_result", result, 5);
    check("busy_start_adder_done", {ad_a, ad_x, ad_d}, 24'h112233);

    // start and abort together in IDLE
    cfg_a = 8'h5A; cfg_x = 8'hA5; cfg_d = 8'h3C; cfg_window = 16'd0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 1);
    check("start_abort_adder", {ad_a, ad_x, ad_d}, 24'h5AA53C);
    wait_done(t0, 30, lat, lat4);
    check("start_abort_latency", lat, 8);
    check("start_abort_result", result, 0);

    // start held high re-triggers on the IDLE cycle after DONE
    @(posedge clk); #1;
    cfg_window = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    wait_done(t0, 30, lat, lat4);
    check("hold_first_latency", lat, 8);
    check("hold_busy_at_done", busy, 0);
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
    check("hold_retrigger_busy", {busy, done}, {1'b1, 1'b0});
    wait_done(t0, 30, lat, lat4);
    check("hold_second_latency", lat, 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
